// File: rtl/md5_padder.sv
// md5_padder: turns a stream of 32-bit little-endian message words into
// 512-bit MD5 blocks. It appends the 0x80 marker and zero fill, and places the
// 64-bit bit length in words 14/15 of the final block. When the marker or the
// length does not fit, it emits one extra block.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-low reset
//   in_data_i[31:0]   message word (byte k in bits [8k+7:8k])
//   in_valid_i        in_data_i / in_last_i / in_nbytes_i valid
//   in_last_i         final word of the message
//   in_nbytes_i[2:0]  valid bytes in the final word (0..4, >4 treated as 4)
//   in_ready_o        a word is accepted this cycle when in_valid_i is high
//   blk_o[511:0]      padded block, word j at bits [32j+31:32j]
//   blk_valid_o       blk_o valid
//   blk_last_o        blk_o is the final (length-carrying) block
//   blk_ready_i       downstream takes blk_o this cycle
//   busy_o            message bytes held or a block in flight
module md5_padder #(
  parameter int LEN_W = 61
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  in_data_i,
  input  logic         in_valid_i,
  input  logic         in_last_i,
  input  logic [2:0]   in_nbytes_i,
  output logic         in_ready_o,
  output logic [511:0] blk_o,
  output logic         blk_valid_o,
  output logic         blk_last_o,
  input  logic         blk_ready_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {ACC = 2'd0, OUT = 2'd1, TAIL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [511:0]       blk_q, blk_d;
  logic               last_q, last_d;
  logic               pend_q, pend_d;   // an extra length block must follow
  logic               mark_q, mark_d;   // that extra block also carries the 0x80 marker
  logic               run_q;            // holds in_ready_o low until the first edge after reset

  logic               accept;
  logic [2:0]         nb;
  logic [6:0]         pos;
  logic [31:0]        last_word;
  logic [63:0]        bitlen;

  assign in_ready_o  = run_q && (state_q == ACC);
  assign accept      = in_valid_i && in_ready_o;
  assign blk_o       = blk_q;
  assign blk_valid_o = (state_q == OUT);
  assign blk_last_o  = last_q;
  assign busy_o      = (state_q != ACC) || (cnt_q != 4'd0) || (len_q != '0);

  // Effective byte count of the incoming word.
  always_comb begin
    if (!in_last_i)              nb = 3'd4;
    else if (in_nbytes_i > 3'd4) nb = 3'd4;
    else                         nb = in_nbytes_i;
  end

  assign pos = {1'b0, cnt_q, 2'b00} + {4'b0000, nb};

  // Final word with unused bytes cleared and the marker in the first free byte
  // (no marker here when the word is full; it then lands in the next word).
  always_comb begin
    last_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nb)       last_word[8*k +: 8] = in_data_i[8*k +: 8];
      else if (3'(k) == nb) last_word[8*k +: 8] = 8'h80;
      else                  last_word[8*k +: 8] = 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    blk_d   = blk_q;
    last_d  = last_q;
    pend_d  = pend_q;
    mark_d  = mark_q;
    bitlen  = '0;

    case (state_q)
      ACC: begin
        if (accept) begin
          len_d  = len_q + LEN_W'(nb);
          bitlen = 64'({len_d, 3'b000});
          if (!in_last_i) begin
            for (int j = 0; j < 16; j++) begin
              if (4'(j) == cnt_q) blk_d[32*j +: 32] = in_data_i;
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = OUT;
              last_d  = 1'b0;
            end
          end else begin
            for (int j = 0; j < 16; j++) begin
              if (j < int'(cnt_q))
                blk_d[32*j +: 32] = blk_q[32*j +: 32];
              else if (j == int'(cnt_q))
                blk_d[32*j +: 32] = last_word;
              else if ((j == int'(cnt_q) + 1) && (nb == 3'd4))
                blk_d[32*j +: 32] = 32'h0000_0080;
              else
                blk_d[32*j +: 32] = 32'h0000_0000;
            end
            cnt_d   = 4'd0;
            state_d = OUT;
            if (pos <= 7'd55) begin
              blk_d[448 +: 32] = bitlen[31:0];
              blk_d[480 +: 32] = bitlen[63:32];
              last_d = 1'b1;
            end else begin
              last_d = 1'b0;
              pend_d = 1'b1;
              mark_d = (pos == 7'd64);
            end
          end
        end
      end

      OUT: begin
        if (blk_ready_i) begin
          if (pend_q) begin
            state_d = TAIL;
          end else begin
            state_d = ACC;
            if (last_q) begin
              cnt_d  = 4'd0;
              len_d  = '0;
              blk_d  = '0;
              last_d = 1'b0;
              pend_d = 1'b0;
              mark_d = 1'b0;
            end
          end
        end
      end

      TAIL: begin
        bitlen           = 64'({len_q, 3'b000});
        blk_d            = '0;
        blk_d[31:0]      = mark_q ? 32'h0000_0080 : 32'h0000_0000;
        blk_d[448 +: 32] = bitlen[31:0];
        blk_d[480 +: 32] = bitlen[63:32];
        pend_d           = 1'b0;
        mark_d           = 1'b0;
        last_d           = 1'b1;
        state_d          = OUT;
      end

      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ACC;
      cnt_q   <= '0;
      len_q   <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      mark_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      mark_q  <= mark_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md5_padder.sv
// tb_md5_padder: random and directed message stimulus for md5_padder. A
// byte-level MD5 padding model predicts every block. The DUT is compared
// against it on each falling clock edge. Literal block values for the classic
// cases pin the model itself.
module tb_md5_padder;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  in_data_i = '0;
  logic         in_valid_i = 1'b0;
  logic         in_last_i = 1'b0;
  logic [2:0]   in_nbytes_i = '0;
  logic         in_ready_o;
  logic [511:0] blk_o;
  logic         blk_valid_o;
  logic         blk_last_o;
  logic         blk_ready_i = 1'b0;
  logic         busy_o;

  md5_padder #(.LEN_W(61)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i),
    .in_nbytes_i(in_nbytes_i), .in_ready_o(in_ready_o),
    .blk_o(blk_o), .blk_valid_o(blk_valid_o), .blk_last_o(blk_last_o),
    .blk_ready_i(blk_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [511:0] d;
    logic         l;
  } blk_t;

  int           n_chk = 0;
  int           n_pass = 0;
  logic [7:0]   pend[$];
  blk_t         expq[$];
  logic [63:0]  msg_total = '0;
  logic         run_m;
  int           gap = 0;
  bit           exp_valid_now = 0;
  int           rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
  logic [511:0] b;
  logic [511:0] b0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic emit_block(input bit l);
    blk_t nb;
    nb.d = '0;
    for (int i = 0; i < 64; i++) nb.d[8*i +: 8] = pend.pop_front();
    nb.l = l;
    expq.push_back(nb);
  endtask

  // Standard MD5 padding on the byte stream of the current message.
  task automatic model_word(input logic [31:0] d, input logic l, input logic [2:0] nbr,
                            output bit pushed);
    int          n;
    logic [63:0] bl;
    pushed = 0;
    n = !l ? 4 : ((nbr > 3'd4) ? 4 : int'(nbr));
    for (int k = 0; k < n; k++) pend.push_back(d[8*k +: 8]);
    msg_total += 64'(n);
    if (!l) begin
      if (pend.size() == 64) begin
        emit_block(1'b0);
        pushed = 1;
      end
    end else begin
      pend.push_back(8'h80);
      while (pend.size() % 64 != 56) pend.push_back(8'h00);
      bl = msg_total << 3;
      for (int k = 0; k < 8; k++) pend.push_back(bl[8*k +: 8]);
      while (pend.size() > 0) emit_block(pend.size() == 64);
      msg_total = '0;
      pushed = 1;
    end
  endtask

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) run_m <= 1'b0;
    else        run_m <= 1'b1;
  end

  always @(negedge clk_i) begin
    bit exp_rdy;
    bit pushed;
    if (!rst_i) begin
      chk("rst_valid", 512'(blk_valid_o), '0);
      chk("rst_last", 512'(blk_last_o), '0);
      chk("rst_ready", 512'(in_ready_o), '0);
      chk("rst_busy", 512'(busy_o), '0);
      chk("rst_blk", blk_o, '0);
      pend.delete();
      expq.delete();
      msg_total = '0;
      gap = 0;
      exp_valid_now = 0;
    end else begin
      exp_rdy = run_m && (expq.size() == 0);
      chk("in_ready", 512'(in_ready_o), 512'(exp_rdy));
      chk("busy", 512'(busy_o), 512'((msg_total != 0) || (expq.size() != 0)));
      if (expq.size() == 0) begin
        chk("valid_idle", 512'(blk_valid_o), '0);
      end else if (blk_valid_o) begin
        chk("blk_data", blk_o, expq[0].d);
        chk("blk_last", 512'(blk_last_o), 512'(expq[0].l));
        gap = 0;
        if (blk_ready_i) void'(expq.pop_front());
      end else begin
        gap++;
        if (exp_valid_now || gap > 1) chk("blk_valid_latency", 512'(blk_valid_o), 512'(1));
      end
      exp_valid_now = 0;
      if (in_valid_i && exp_rdy) begin
        model_word(in_data_i, in_last_i, in_nbytes_i, pushed);
        exp_valid_now = pushed;
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0:       blk_ready_i = ($urandom_range(0, 3) != 0);
      1:       blk_ready_i = 1'b0;
      default: blk_ready_i = 1'b1;
    endcase
  end

  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb, input bit gaps);
    int budget = 0;
    in_data_i = d; in_last_i = l; in_nbytes_i = nb; in_valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (in_ready_o) break;
      budget++;
      if (budget > 300) begin
        chk("send_timeout", 512'(in_ready_o), 512'(1));
        break;
      end
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    in_data_i = $urandom;
    if (gaps) repeat ($urandom_range(0, 1)) @(posedge clk_i);
    if (gaps) #1;
  endtask

  task automatic send_msg(input int nfull, input logic [2:0] lastnb, input bit gaps);
    for (int i = 0; i < nfull; i++) send_word($urandom, 1'b0, 3'($urandom_range(0, 7)), gaps);
    send_word($urandom, 1'b1, lastnb, gaps);
  endtask

  task automatic wait_last(output logic [511:0] r);
    bit got = 0;
    r = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      if (blk_valid_o && blk_last_o) begin
        r = blk_o;
        got = 1;
      end
    end
    if (!got) chk("wait_last_timeout", 512'(got), 512'(1));
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk_i);
      if (expq.size() == 0 && in_ready_o) done = 1;
    end
    if (!done) chk("drain_timeout", 512'(done), 512'(1));
    @(posedge clk_i); #1;
  endtask

  localparam logic [511:0] ABC_BLK = (512'h18 << 448) | 512'h8063_6261;

  initial begin
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // empty message
    send_word(32'hDEAD_BEEF, 1'b1, 3'd0, 0);
    wait_last(b);
    chk("empty_blk", b, 512'h80);

    // "abc" with a stray byte in the unused lane
    send_word(32'hFF63_6261, 1'b1, 3'd3, 0);
    wait_last(b);
    chk("abc_blk", b, ABC_BLK);
    chk("abc_word0", 512'(b[31:0]), 512'h8063_6261);

    // p = 60: marker in word 15, length in a second block
    send_msg(14, 3'd4, 0);
    wait_last(b);
    chk("p60_tail", b, 512'h1E0 << 448);

    // p = 64: marker moves into the second block
    send_msg(15, 3'd4, 0);
    wait_last(b);
    chk("p64_tail", b, (512'h200 << 448) | 512'h80);

    // boundaries around 55/56 and clamped byte count
    send_msg(13, 3'd3, 0);
    send_msg(14, 3'd0, 0);
    send_msg(13, 3'd7, 1);
    send_msg(3, 3'd6, 1);
    drain();

    // stalled output: block held, new word not taken
    rdy_mode = 1;
    send_word(32'h0063_6261, 1'b1, 3'd3, 0);
    in_data_i = 32'hA5A5_0011; in_last_i = 1'b1; in_nbytes_i = 3'd2; in_valid_i = 1'b1;
    @(negedge clk_i);
    b0 = blk_o;
    chk("stall_valid", 512'(blk_valid_o), 512'(1));
    chk("stall_abc", b0, ABC_BLK);
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_ready", 512'(in_ready_o), '0);
      chk("stall_stable", blk_o, b0);
    end
    rdy_mode = 2;
    begin
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk_i);
        if (in_ready_o) ok = 1;
      end
      if (!ok) chk("stall_release", 512'(ok), 512'(1));
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    drain();

    // reset mid-message
    for (int i = 0; i < 7; i++) send_word($urandom, 1'b0, 3'd4, 0);
    rst_i = 1'b0;
    #1;
    chk("async_rst_busy", 512'(busy_o), '0);
    chk("async_rst_blk", blk_o, '0);
    chk("async_rst_ready", 512'(in_ready_o), '0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // reset while a block is presented
    rdy_mode = 1;
    send_word(32'h0063_6261, 1'b1, 3'd3, 0);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("rst_out_valid", 512'(blk_valid_o), '0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    rdy_mode = 2;
    send_word(32'h0063_6261, 1'b1, 3'd3, 0);
    wait_last(b);
    chk("abc_after_rst", b, ABC_BLK);

    // random messages with random back-pressure
    rdy_mode = 0;
    for (int m = 0; m < 30; m++) begin
      int nf;
      nf = ($urandom_range(0, 2) == 0) ? $urandom_range(12, 16) : $urandom_range(0, 40);
      send_msg(nf, 3'($urandom_range(0, 7)), 1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
